coeff_bank_server: RTL and testbench

Coefficient responder for the 8-band FIR filter bank. It answers the bank's coeffaddress reads with eight packed 36-bit coefficient words, one per band. It also accepts a runtime coefficient download into a shadow bank, and swaps the shadow bank in only at a frame boundary. The swap point is the filter bank's din_enable, so a frame never mixes old and new coefficients.

---
 rtl/coeff_bank_server_pkg.sv | 38 +++
 rtl/coeff_bank_server_pair_ram.sv | 40 ++++
 rtl/coeff_bank_server.sv | 176 +++++++++++++++++
 tb/tb_coeff_bank_server.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/coeff_bank_server_pkg.sv
// Shared definitions for the coefficient bank server.
// Provides sizing constants, the load FSM state encoding, the bit positions
// of the two taps inside a packed pair word, and a pair-packing helper.
package coeff_bank_server_pkg;

  localparam int NBANDS = 8;    // band filters served (coeff0..coeff7)
  localparam int NTAPS  = 128;  // taps per band
  localparam int CW     = 18;   // bits per coefficient
  localparam int AW     = 6;    // tap-pair address width (NTAPS/2 words)
  localparam int CNTW   = 10;   // download counter width (NBANDS*NTAPS accepts)
  localparam int PW     = 2*CW; // packed pair word width
  localparam int BW     = 3;    // band index width

  // Pair-word field positions: even tap in the low half, odd tap in the high half.
  localparam int EVEN_LSB = 0;
  localparam int EVEN_MSB = CW-1;
  localparam int ODD_LSB  = CW;
  localparam int ODD_MSB  = PW-1;

  // Count value of the final coefficient of a download.
  localparam logic [CNTW-1:0] LAST_COUNT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2
  } load_state_t;

  function automatic logic [PW-1:0] pack_pair(input logic [CW-1:0] odd_tap,
                                              input logic [CW-1:0] even_tap);
    logic [PW-1:0] w;
    w = '0;
    w[EVEN_MSB:EVEN_LSB] = even_tap;
    w[ODD_MSB:ODD_LSB]   = odd_tap;
    return w;
  endfunction

endpackage

// File: rtl/coeff_bank_server_pair_ram.sv
// coeff_pair_ram: 64 x 36 synchronous-read RAM holding the tap pairs of one
// band in one bank. One write port, one read port.
// Ports:
//   clock    - system clock
//   reset    - asynchronous active-low reset (clears only the read register)
//   wr_en    - write strobe
//   wr_addr  - write word address
//   wr_data  - packed pair word to store
//   rd_addr  - read word address, sampled every rising edge
//   rd_data  - registered read word (old contents on a same-address write)
module coeff_pair_ram
  import coeff_bank_server_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [PW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [PW-1:0] rd_data
);

  logic [PW-1:0] mem [0:(1<<AW)-1];

  // Storage array carries no reset so it maps onto RAM macros.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/coeff_bank_server.sv
// coeff_bank_server: coefficient responder for the 8-band FIR filter bank.
// Serves one packed tap pair per band per cycle from the active bank, accepts
// a 1024-coefficient download into the shadow bank, and swaps banks only on a
// frame boundary (frame_sync) so a frame never mixes coefficient sets.
// Ports:
//   clock, reset            - clock; asynchronous active-low reset
//   coeffaddress            - tap-pair address from the filter bank
//   coeff0..coeff7          - pair word for each band, 1-clock read latency
//   frame_sync              - frame boundary (filter bank din_enable)
//   load_start, load_abort  - begin / discard a download
//   load_data, load_valid   - download stream, band-major then tap order
//   load_ready              - download word accepted when load_valid is high
//   load_done               - one-cycle pulse after the bank swap edge
//   bank_valid              - active bank holds a completed download
//   active_sel              - index of the bank currently served
//   load_state              - load FSM state (debug)
// Handshake: a coefficient is transferred on a rising edge where
// load_valid && load_ready; load_ready is high only in LOAD with no abort
// pending, and load_data must be held while load_valid waits for load_ready.
module coeff_bank_server
  import coeff_bank_server_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [AW-1:0]     coeffaddress,
  output logic [PW-1:0]     coeff0,
  output logic [PW-1:0]     coeff1,
  output logic [PW-1:0]     coeff2,
  output logic [PW-1:0]     coeff3,
  output logic [PW-1:0]     coeff4,
  output logic [PW-1:0]     coeff5,
  output logic [PW-1:0]     coeff6,
  output logic [PW-1:0]     coeff7,
  input  logic              frame_sync,
  input  logic              load_start,
  input  logic              load_abort,
  input  logic [CW-1:0]     load_data,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              load_done,
  output logic              bank_valid,
  output logic              active_sel,
  output load_state_t       load_state
);

  load_state_t     state_q, state_d;
  logic [CNTW-1:0] count_q;
  logic [CW-1:0]   hold_q;
  logic            active_q;
  logic            read_sel_q;
  logic            bank_valid_q;
  logic            load_done_q;
  logic            ready;
  logic            accept;
  logic            swap;
  logic            start_load;

  // Download address decode.
  logic [BW-1:0]   wr_band;
  logic [AW-1:0]   wr_addr;
  logic            wr_pair;
  logic [PW-1:0]   wr_word;

  assign wr_band = count_q[CNTW-1 -: BW];
  assign wr_addr = count_q[AW:1];
  assign wr_pair = accept && count_q[0];
  assign wr_word = pack_pair(load_data, hold_q);

  // Next-state and handshake decode. Abort wins over a same-cycle accept or
  // frame_sync so an aborted download can neither write nor swap.
  always_comb begin
    state_d    = state_q;
    ready      = 1'b0;
    accept     = 1'b0;
    swap       = 1'b0;
    start_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start && !load_abort) begin
          start_load = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (load_abort) begin
          state_d = IDLE;
        end else begin
          ready  = 1'b1;
          accept = load_valid;
          if (load_valid && (count_q == LAST_COUNT)) begin
            state_d = PEND;
          end
        end
      end
      PEND: begin
        if (load_abort) begin
          state_d = IDLE;
        end else if (frame_sync) begin
          swap    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      hold_q       <= '0;
      active_q     <= 1'b0;
      read_sel_q   <= 1'b0;
      bank_valid_q <= 1'b0;
      load_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_done_q <= swap;
      // The read mux follows the bank selected when the address was sampled,
      // so the word read on the swap edge still comes from the old bank.
      read_sel_q  <= active_q;
      if (start_load) begin
        count_q <= '0;
      end else if (accept) begin
        count_q <= count_q + 1'b1;
      end
      if (accept && !count_q[0]) begin
        hold_q <= load_data;
      end
      if (swap) begin
        active_q     <= ~active_q;
        bank_valid_q <= 1'b1;
      end
    end
  end

  // Two banks x NBANDS bands of pair RAM. Writes only ever target the shadow
  // bank (the one not selected by active_q).
  logic [PW-1:0] rd_word [2][NBANDS];
  logic [PW-1:0] coeff_mux [NBANDS];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar n = 0; n < NBANDS; n++) begin : g_band
      logic we;
      assign we = wr_pair && (wr_band == BW'(n)) && (active_q != 1'(b));
      coeff_pair_ram u_ram (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (we),
        .wr_addr (wr_addr),
        .wr_data (wr_word),
        .rd_addr (coeffaddress),
        .rd_data (rd_word[b][n])
      );
    end
  end

  for (genvar n = 0; n < NBANDS; n++) begin : g_mux
    assign coeff_mux[n] = read_sel_q ? rd_word[1][n] : rd_word[0][n];
  end

  assign coeff0     = coeff_mux[0];
  assign coeff1     = coeff_mux[1];
  assign coeff2     = coeff_mux[2];
  assign coeff3     = coeff_mux[3];
  assign coeff4     = coeff_mux[4];
  assign coeff5     = coeff_mux[5];
  assign coeff6     = coeff_mux[6];
  assign coeff7     = coeff_mux[7];
  assign load_ready = ready;
  assign load_done  = load_done_q;
  assign bank_valid = bank_valid_q;
  assign active_sel = active_q;
  assign load_state = state_q;

endmodule

// File: tb/tb_coeff_bank_server.sv
// Bench for coeff_bank_server: random downloads with gaps, mid-load
// frame_sync, abort and reset, checked against a tap-indexed bank model.
module tb_coeff_bank_server;
  import coeff_bank_server_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  coeffaddress = '0;
  logic [35:0] coeff0, coeff1, coeff2, coeff3, coeff4, coeff5, coeff6, coeff7;
  logic        frame_sync = 1'b0;
  logic        load_start = 1'b0;
  logic        load_abort = 1'b0;
  logic [17:0] load_data = '0;
  logic        load_valid = 1'b0;
  logic        load_ready, load_done, bank_valid, active_sel;
  load_state_t load_state;

  // clock / reset block
  always #5 clock = ~clock;

  coeff_bank_server dut (
    .clock(clock), .reset(reset), .coeffaddress(coeffaddress),
    .coeff0(coeff0), .coeff1(coeff1), .coeff2(coeff2), .coeff3(coeff3),
    .coeff4(coeff4), .coeff5(coeff5), .coeff6(coeff6), .coeff7(coeff7),
    .frame_sync(frame_sync), .load_start(load_start), .load_abort(load_abort),
    .load_data(load_data), .load_valid(load_valid), .load_ready(load_ready),
    .load_done(load_done), .bank_valid(bank_valid), .active_sel(active_sel),
    .load_state(load_state)
  );

  logic [35:0] coeff_all [8];
  assign coeff_all[0] = coeff0;
  assign coeff_all[1] = coeff1;
  assign coeff_all[2] = coeff2;
  assign coeff_all[3] = coeff3;
  assign coeff_all[4] = coeff4;
  assign coeff_all[5] = coeff5;
  assign coeff_all[6] = coeff6;
  assign coeff_all[7] = coeff7;

  typedef struct packed {
    logic             known;
    logic [7:0][35:0] coeff;
    logic             sel;
    logic             valid;
    logic             done;
    logic             ready;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);
  logic [EXP_W-1:0] exp_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model: taps indexed band*128+tap; mode 0 idle, 1 loading, 2 pending.
  int          m_mode  = 0;
  int          m_n     = 0;
  logic [17:0] sh  [1024];
  logic [17:0] act [1024];
  logic        m_sel   = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_known = 1'b0;
  int          m_swaps = 0;
  int          done_seen = 0;
  bit          chk_en  = 1'b0;
  int          addr_mode = 0; // 0 random, 1 sweep, 2 hold

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference: sample inputs on each rising edge, push the outputs expected after it.
  always @(posedge clock) begin
    exp_t e;
    if (chk_en) begin
      e.known = m_known;
      for (int n = 0; n < 8; n++) begin
        e.coeff[n] = {act[n*128 + 2*int'(coeffaddress) + 1], act[n*128 + 2*int'(coeffaddress)]};
      end
      e.done = 1'b0;
      case (m_mode)
        0: if (load_start && !load_abort) begin m_mode = 1; m_n = 0; end
        1: begin
          if (load_abort) m_mode = 0;
          else if (load_valid) begin
            sh[m_n] = load_data;
            m_n++;
            if (m_n == 1024) m_mode = 2;
          end
        end
        default: begin
          if (load_abort) m_mode = 0;
          else if (frame_sync) begin
            act = sh;
            m_sel = ~m_sel;
            m_valid = 1'b1;
            m_known = 1'b1;
            e.done = 1'b1;
            m_swaps++;
            m_mode = 0;
          end
        end
      endcase
      e.sel   = m_sel;
      e.valid = m_valid;
      e.ready = (m_mode == 1) && !load_abort;
      exp_q.push_back(e);
    end
  end

  // Monitor: compare DUT outputs 1 time unit after each rising edge.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (chk_en && exp_q.size() > 0) begin
      e = exp_t'(exp_q.pop_front());
      if (e.known) begin
        for (int n = 0; n < 8; n++) begin
          check($sformatf("coeff%0d", n), 64'(coeff_all[n]), 64'(e.coeff[n]));
        end
      end
      check("active_sel", 64'(active_sel), 64'(e.sel));
      check("bank_valid", 64'(bank_valid), 64'(e.valid));
      check("load_done",  64'(load_done),  64'(e.done));
      check("load_ready", 64'(load_ready), 64'(e.ready));
      if (load_done) done_seen++;
    end
  end

  // Address driver.
  initial begin
    forever begin
      @(negedge clock);
      if (addr_mode == 0) coeffaddress = 6'($urandom_range(0, 63));
      else if (addr_mode == 1) coeffaddress = coeffaddress + 6'd1;
    end
  end

  task automatic check_reset_outputs(input string tag);
    for (int n = 0; n < 8; n++) check($sformatf("%s_coeff%0d", tag, n), 64'(coeff_all[n]), 64'd0);
    check({tag, "_load_ready"}, 64'(load_ready), 64'd0);
    check({tag, "_load_done"},  64'(load_done),  64'd0);
    check({tag, "_bank_valid"}, 64'(bank_valid), 64'd0);
    check({tag, "_active_sel"}, 64'(active_sel), 64'd0);
  endtask

  task automatic do_mid_reset();
    #2;
    chk_en = 1'b0;
    reset  = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    m_mode = 0; m_n = 0; m_sel = 1'b0; m_valid = 1'b0; m_known = 1'b0;
    load_valid = 1'b0; load_start = 1'b0; load_abort = 1'b0; frame_sync = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk_en = 1'b1;
  endtask

  // pat 0: band*256+tap, 1: its negation, else random.
  task automatic download(input int pat, input bit gaps, input int fsync_at,
                          input int abort_at, input int reset_at);
    logic [17:0] dl [1024];
    int guard;
    for (int i = 0; i < 1024; i++) begin
      case (pat)
        0: dl[i] = 18'((i / 128) * 256 + (i % 128));
        1: dl[i] = 18'(-((i / 128) * 256 + (i % 128)));
        default: dl[i] = 18'($urandom);
      endcase
    end
    @(negedge clock); load_start = 1'b1;
    @(negedge clock); load_start = 1'b0;
    guard = 0;
    while (m_mode == 1 && guard < 6000) begin
      if (abort_at >= 0 && m_n == abort_at) begin
        load_valid = 1'b0; load_abort = 1'b1;
        @(negedge clock);
        load_abort = 1'b0;
        break;
      end
      if (reset_at >= 0 && m_n == reset_at) begin
        do_mid_reset();
        break;
      end
      frame_sync = (fsync_at >= 0 && m_n == fsync_at);
      load_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      load_data  = dl[m_n];
      @(negedge clock);
      guard++;
    end
    load_valid = 1'b0;
    frame_sync = 1'b0;
    if (guard >= 6000) check("download_bound", 64'd1, 64'd0);
    if (abort_at < 0 && reset_at < 0) check("pend_state", 64'(load_state), 64'(PEND));
  endtask

  task automatic pulse_fsync();
    @(negedge clock); frame_sync = 1'b1;
    @(negedge clock); frame_sync = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clock);
    chk_en = 1'b1;

    // Gap-free ramp download and swap.
    download(0, 1'b0, -1, -1, -1);
    pulse_fsync();
    check("done_count_1", 64'(done_seen), 64'd1);
    @(negedge clock); addr_mode = 2; coeffaddress = 6'd5;
    @(posedge clock); #1;
    check("coeff3_even_a5", 64'(coeff3[17:0]), 64'd778);
    check("coeff3_odd_a5",  64'(coeff3[35:18]), 64'd779);
    check("sel_after_swap1", 64'(active_sel), 64'd1);
    @(negedge clock); addr_mode = 1;

    // Negated download while sweeping addresses.
    download(1, 1'b0, -1, -1, -1);
    pulse_fsync();
    @(negedge clock); addr_mode = 2; coeffaddress = 6'd0;
    @(posedge clock); #1;
    check("coeff0_odd_neg1", 64'(coeff0[35:18]), 64'h3FFFF);
    check("coeff0_even_0",   64'(coeff0[17:0]),  64'd0);
    check("done_count_2", 64'(done_seen), 64'd2);
    @(negedge clock); addr_mode = 0;

    // Random gaps, frame_sync during LOAD at count 500.
    download(0, 1'b1, 500, -1, -1);
    check("sel_before_swap3", 64'(active_sel), 64'd0);
    pulse_fsync();
    check("done_count_3", 64'(done_seen), 64'd3);

    // Abort at count 700, then frame_sync: no swap.
    download(2, 1'b1, -1, 700, -1);
    pulse_fsync();
    repeat (20) @(negedge clock);
    check("abort_sel", 64'(active_sel), 64'd1);
    check("done_count_abort", 64'(done_seen), 64'd3);

    // Reset mid-load, then a full download and swap.
    download(2, 1'b1, -1, -1, 300);
    download(2, 1'b0, -1, -1, -1);
    pulse_fsync();
    repeat (70) @(negedge clock);
    check("sel_after_reset_swap", 64'(active_sel), 64'd1);
    check("done_count_final", 64'(done_seen), 64'd4);
    check("queue_drain", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
